// File: rtl/serdes_pkg.sv
// serdes_pkg: shared state encoding and line levels for the serial lane.
// Imported by both the serializer and the far-side deserializer.
// Keep the encoding stable: both ends of the link depend on these names.
package serdes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    START,
    DATA,
    PARITY,
    STOP
  } ser_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops one word per frame from the FIFO read port and sends it on a 1-bit lane
//   (idle high, start 0, data LSB first, optional even parity, stop 1). Optional macro: SER_PARITY_EN.
// Latency: o_rr 1 cycle after IDLE sees !i_rempty; start bit 2 cycles after o_rr; 3 high cycles between frames.
// Backpressure: none mid-frame; i_rempty is only looked at in IDLE, so at most one read per frame.
module fifo_serializer
  import serdes_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic              ref_clk,
  input  logic              i_rst_n,
  input  logic              i_rempty,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_rr,
  output logic              o_sdata,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic [CNT_W-1:0]  o_tx_count
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef SER_PARITY_EN
  localparam ser_state_t AFTER_DATA = PARITY;
`else
  localparam ser_state_t AFTER_DATA = STOP;
`endif

  ser_state_t        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d, tmr_inc;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rr_q, rr_d;
  logic              sdata_q, sdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;
`ifdef SER_PARITY_EN
  logic              par_q, par_d;
`endif

  assign bit_end = (tmr_q == TMR_LAST);
  assign tmr_inc = bit_end ? '0 : tmr_q + TMR_W'(1);

  // Next state, bit timer, shift register, frame counter and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    tmr_d   = '0;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: if (!i_rempty) state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        // FIFO data is valid now, one cycle after the read request.
        shreg_d = i_rdata;
`ifdef SER_PARITY_EN
        par_d   = ^i_rdata;
`endif
        state_d = START;
      end
      START: begin
        tmr_d = tmr_inc;
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        tmr_d = tmr_inc;
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == IDX_LAST) state_d = AFTER_DATA;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      PARITY: begin
        tmr_d = tmr_inc;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        tmr_d = tmr_inc;
        if (bit_end) begin
          state_d = IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet aligned with state_q.
    rr_d   = (state_d == REQ);
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (tmr_d == TMR_LAST);
    case (state_d)
      START:   sdata_d = START_BIT;
      DATA:    sdata_d = shreg_d[0];
`ifdef SER_PARITY_EN
      PARITY:  sdata_d = par_d;
`endif
      STOP:    sdata_d = STOP_BIT;
      default: sdata_d = IDLE_LVL;
    endcase
  end

  // State and datapath registers; synchronous reset drops any partial frame.
  always_ff @(posedge ref_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      sdata_q <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      sdata_q <= sdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_rr         = rr_q;
  assign o_sdata      = sdata_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_tx_count   = cnt_q;

endmodule
